// File: rtl/pwm_capture.sv
// ---------------------------------------------------------------------------
// pwm_capture
//
// Measures the period and high time of a square / PWM waveform in clk cycles.
// Each rising edge of the input closes one measurement: period_out and
// high_out are loaded and valid pulses for one cycle. When no rising edge
// arrives for TIMEOUT cycles the outputs are cleared and stalled is raised.
// stalled stays high until the next measurement.
//
// The first rising edge after reset or after a timeout only arms the block,
// so the first valid needs two rising edges.
//
// Build option (macro): PWM_CAPTURE_SYNC_EN
//   defined   : pwm_in goes through a two-flop synchroniser
//               (asynchronous / off-chip source, +1 cycle latency)
//   undefined : pwm_in goes through a single register
//               (source must be in the clk domain)
//   The measured values are identical in both builds.
//
// Parameters
//   WIDTH   : width of the counters and of the measurement outputs
//   TIMEOUT : cycles without a rising edge before stalled asserts
//             (2 <= TIMEOUT < 2**WIDTH - 1)
//
// Ports
//   clk        in   clock, rising edge active
//   reset_n    in   asynchronous active-low reset
//   pwm_in     in   waveform to measure
//   period_out out  cycles between the last two rising edges
//   high_out   out  cycles high within that period
//   valid      out  one-cycle pulse when period_out/high_out update
//   stalled    out  level, high while the input has timed out
// ---------------------------------------------------------------------------
module pwm_capture #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 1_000_000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             pwm_in,
    output logic [WIDTH-1:0] period_out,
    output logic [WIDTH-1:0] high_out,
    output logic             valid,
    output logic             stalled
);

    localparam logic [WIDTH-1:0] TIMEOUT_W = WIDTH'(TIMEOUT);
    localparam logic [WIDTH-1:0] ONE_W     = WIDTH'(1);

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } state_t;

    // Input stage. All input flops reset to 1 so that an input already high
    // at reset release is not mistaken for a rising edge.
    logic r_sample;
    logic r_sample_d;

`ifdef PWM_CAPTURE_SYNC_EN
    logic r_sync_meta;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync_meta <= 1'b1;
            r_sample    <= 1'b1;
        end else begin
            r_sync_meta <= pwm_in;
            r_sample    <= r_sync_meta;
        end
    end
`else
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sample <= 1'b1;
        end else begin
            r_sample <= pwm_in;
        end
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sample_d <= 1'b1;
        end else begin
            r_sample_d <= r_sample;
        end
    end

    logic w_rise;
    assign w_rise = r_sample & ~r_sample_d;

    // Measurement state machine with registered outputs.
    state_t           r_state;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_period_out;
    logic [WIDTH-1:0] r_high_out;
    logic             r_valid;
    logic             r_stalled;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_hi         <= '0;
            r_period_out <= '0;
            r_high_out   <= '0;
            r_valid      <= 1'b0;
            r_stalled    <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    // First edge only arms; there is no previous edge to
                    // measure from.
                    if (w_rise) begin
                        r_cnt   <= ONE_W;
                        r_hi    <= ONE_W;
                        r_state <= MEASURE;
                    end
                end
                MEASURE: begin
                    if (w_rise) begin
                        r_period_out <= r_cnt;
                        r_high_out   <= r_hi;
                        r_valid      <= 1'b1;
                        r_stalled    <= 1'b0;
                        r_cnt        <= ONE_W;
                        r_hi         <= ONE_W;
                    end else if (r_cnt == TIMEOUT_W) begin
                        r_period_out <= '0;
                        r_high_out   <= '0;
                        r_stalled    <= 1'b1;
                        r_state      <= IDLE;
                    end else begin
                        // cnt is capped by TIMEOUT and hi <= cnt, so neither
                        // counter can wrap.
                        r_cnt <= r_cnt + ONE_W;
                        r_hi  <= r_hi + {{(WIDTH-1){1'b0}}, r_sample};
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign period_out = r_period_out;
    assign high_out   = r_high_out;
    assign valid      = r_valid;
    assign stalled    = r_stalled;

endmodule

// File: tb/tb_pwm_capture.sv
// ---------------------------------------------------------------------------
// tb_pwm_capture
//
// Drives pwm_capture with directed and random clk-synchronous waveforms and
// compares every cycle against a reference model that works from absolute
// edge times: period = time between rising edges, high = number of high
// samples in that interval, timeout = TIMEOUT samples after the last rise.
// The model result is delayed by the input-stage latency before comparison.
// A second instance with a longer timeout is fed by a period-100 generator.
// ---------------------------------------------------------------------------
module tb_pwm_capture;

    localparam int W     = 16;
    localparam int TO    = 64;
    localparam int TO_LB = 256;
`ifdef PWM_CAPTURE_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic         clk     = 1'b0;
    logic         reset_n = 1'b0;
    logic         pwm_in  = 1'b1;
    logic         pwm_lb  = 1'b1;
    logic [W-1:0] period_out, high_out, lb_period, lb_high;
    logic         valid, stalled, lb_valid, lb_stalled;

    pwm_capture #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .pwm_in     (pwm_in),
        .period_out (period_out),
        .high_out   (high_out),
        .valid      (valid),
        .stalled    (stalled)
    );

    pwm_capture #(.WIDTH(W), .TIMEOUT(TO_LB)) dut_lb (
        .clk        (clk),
        .reset_n    (reset_n),
        .pwm_in     (pwm_lb),
        .period_out (lb_period),
        .high_out   (lb_high),
        .valid      (lb_valid),
        .stalled    (lb_stalled)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic         v;
        logic         s;
        logic [W-1:0] p;
        logic [W-1:0] h;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   gcyc   = 0;

    // Reference model state
    bit           m_prev;
    bit           m_armed;
    int           m_last;
    int           m_hcnt;
    int           m_cyc;
    logic [W-1:0] m_period;
    logic [W-1:0] m_high;
    bit           m_stall;

    task automatic model_reset();
        m_prev   = 1'b1;
        m_armed  = 1'b0;
        m_last   = 0;
        m_hcnt   = 0;
        m_cyc    = 0;
        m_period = '0;
        m_high   = '0;
        m_stall  = 1'b0;
        q.delete();
        for (int i = 0; i < LAT; i++) q.push_back('0);
    endtask

    // Drive one input sample, advance one clock, and return what the DUT
    // should show right now.
    task automatic cycle(input bit x, output exp_t e);
        exp_t now;
        bit   rise;
        pwm_in = x;
        pwm_lb = ((gcyc % 100) < 50);
        @(posedge clk);
        #1;
        now  = '0;
        rise = x && !m_prev;
        if (rise) begin
            if (m_armed) begin
                now.v    = 1'b1;
                m_period = W'(m_cyc - m_last);
                m_high   = W'(m_hcnt);
                m_stall  = 1'b0;
            end
            m_armed = 1'b1;
            m_last  = m_cyc;
            m_hcnt  = 0;
        end else if (m_armed && (m_cyc - m_last == TO)) begin
            m_period = '0;
            m_high   = '0;
            m_stall  = 1'b1;
            m_armed  = 1'b0;
        end
        m_hcnt += int'(x);
        m_prev  = x;
        now.s = m_stall;
        now.p = m_period;
        now.h = m_high;
        q.push_back(now);
        e = q.pop_front();
        m_cyc++;
        gcyc++;
    endtask

    function automatic bit wave(int i, int p, int h);
        return (i % p) < h;
    endfunction

    task automatic test_reset();
        exp_t e;
        int   nv_a, nv;
        bit   x;
        reset_n = 1'b0;
        pwm_in  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({valid, stalled, period_out, high_out} !== '0) begin
            errors++;
            $display("FAIL reset_state got v=%b s=%b p=%0d h=%0d exp all zero",
                     valid, stalled, period_out, high_out);
        end
        reset_n = 1'b1;
        model_reset();
        nv_a = 0;
        nv   = 0;
        for (int i = 0; i < 30; i++) begin
            x = (i < 6) || (i >= 10 && i < 15) || (i >= 20 && i < 25);
            cycle(x, e);
            checks++;
            if ({valid, stalled, period_out, high_out} !== e) begin
                errors++;
                $display("FAIL reset_rearm cyc=%0d got v=%b s=%b p=%0d h=%0d exp v=%b s=%b p=%0d h=%0d",
                         i, valid, stalled, period_out, high_out, e.v, e.s, e.p, e.h);
            end
            if (valid) begin
                nv++;
                if (i < 20) nv_a++;
                $display("reset_rearm: valid period=%0d high=%0d", period_out, high_out);
            end
        end
        checks++;
        if (nv_a !== 0) begin
            errors++;
            $display("FAIL reset_no_early_valid got %0d valids exp 0", nv_a);
        end
        checks++;
        if (nv !== 1) begin
            errors++;
            $display("FAIL reset_two_rises got %0d valids exp 1", nv);
        end
    endtask

    task automatic test_nominal();
        exp_t e;
        int   last_v;
        last_v = -1;
        for (int i = 0; i < 60; i++) begin
            cycle(wave(i, 10, 5), e);
            checks++;
            if ({valid, stalled, period_out, high_out} !== e) begin
                errors++;
                $display("FAIL nominal cyc=%0d got v=%b s=%b p=%0d h=%0d exp v=%b s=%b p=%0d h=%0d",
                         i, valid, stalled, period_out, high_out, e.v, e.s, e.p, e.h);
            end
            if (valid) begin
                $display("nominal: valid period=%0d high=%0d", period_out, high_out);
                if (last_v >= 0) begin
                    checks++;
                    if (i - last_v !== 10) begin
                        errors++;
                        $display("FAIL nominal_spacing got %0d exp 10", i - last_v);
                    end
                end
                last_v = i;
            end
        end
    endtask

    task automatic test_odd_min();
        exp_t e;
        int   nv;
        for (int i = 0; i < 35; i++) begin
            cycle(wave(i, 7, 3), e);
            checks++;
            if ({valid, stalled, period_out, high_out} !== e) begin
                errors++;
                $display("FAIL odd cyc=%0d got v=%b s=%b p=%0d h=%0d exp v=%b s=%b p=%0d h=%0d",
                         i, valid, stalled, period_out, high_out, e.v, e.s, e.p, e.h);
            end
            if (valid) $display("odd: valid period=%0d high=%0d", period_out, high_out);
        end
        nv = 0;
        for (int i = 0; i < 30; i++) begin
            cycle(wave(i, 2, 1), e);
            checks++;
            if ({valid, stalled, period_out, high_out} !== e) begin
                errors++;
                $display("FAIL min cyc=%0d got v=%b s=%b p=%0d h=%0d exp v=%b s=%b p=%0d h=%0d",
                         i, valid, stalled, period_out, high_out, e.v, e.s, e.p, e.h);
            end
            if (i >= 10 && valid) nv++;
        end
        checks++;
        if (nv !== 10) begin
            errors++;
            $display("FAIL min_period_count got %0d valids exp 10", nv);
        end
    endtask

    task automatic test_timeout();
        exp_t e;
        int   last_v, st_at, fv, sd;
        bit   x;
        last_v = -1;
        st_at  = -1;
        for (int i = 0; i < 140; i++) begin
            x = (i < 40) ? wave(i, 10, 5) : 1'b1;
            cycle(x, e);
            checks++;
            if ({valid, stalled, period_out, high_out} !== e) begin
                errors++;
                $display("FAIL timeout cyc=%0d got v=%b s=%b p=%0d h=%0d exp v=%b s=%b p=%0d h=%0d",
                         i, valid, stalled, period_out, high_out, e.v, e.s, e.p, e.h);
            end
            if (valid) last_v = i;
            if (stalled && st_at < 0) begin
                st_at = i;
                $display("timeout: stalled period=%0d high=%0d", period_out, high_out);
            end
        end
        checks++;
        if (st_at - last_v !== TO) begin
            errors++;
            $display("FAIL timeout_delay got %0d exp %0d", st_at - last_v, TO);
        end
        fv = -1;
        sd = -1;
        for (int i = 0; i < 45; i++) begin
            x = (i < 5) ? 1'b0 : wave(i - 5, 10, 5);
            cycle(x, e);
            checks++;
            if ({valid, stalled, period_out, high_out} !== e) begin
                errors++;
                $display("FAIL resume cyc=%0d got v=%b s=%b p=%0d h=%0d exp v=%b s=%b p=%0d h=%0d",
                         i, valid, stalled, period_out, high_out, e.v, e.s, e.p, e.h);
            end
            if (valid && fv < 0) fv = i;
            if (!stalled && sd < 0) sd = i;
        end
        checks++;
        if (fv !== sd || fv !== 15 + LAT) begin
            errors++;
            $display("FAIL resume_first_valid got valid@%0d unstall@%0d exp both %0d",
                     fv, sd, 15 + LAT);
        end
    endtask

    task automatic test_latency();
        exp_t e;
        int   found;
        bit   x;
        for (int i = 0; i < 10; i++) begin
            x = (i == 3);
            cycle(x, e);
            checks++;
            if ({valid, stalled, period_out, high_out} !== e) begin
                errors++;
                $display("FAIL latency_pre cyc=%0d got v=%b s=%b p=%0d h=%0d exp v=%b s=%b p=%0d h=%0d",
                         i, valid, stalled, period_out, high_out, e.v, e.s, e.p, e.h);
            end
        end
        cycle(1'b1, e);  // edge k: first edge that samples the input high
        found = -1;
        for (int j = 1; j <= 6; j++) begin
            cycle(1'b1, e);
            checks++;
            if ({valid, stalled, period_out, high_out} !== e) begin
                errors++;
                $display("FAIL latency cyc=%0d got v=%b s=%b p=%0d h=%0d exp v=%b s=%b p=%0d h=%0d",
                         j, valid, stalled, period_out, high_out, e.v, e.s, e.p, e.h);
            end
            if (valid && found < 0) found = j;
        end
        checks++;
        if (found !== LAT) begin
            errors++;
            $display("FAIL latency_edges got %0d exp %0d", found, LAT);
        end
    endtask

    task automatic test_midreset();
        exp_t e;
        for (int i = 0; i < 25; i++) cycle(wave(i, 10, 5), e);
        reset_n = 1'b0;
        #1;
        checks++;
        if ({valid, stalled, period_out, high_out} !== '0) begin
            errors++;
            $display("FAIL midreset_clear got v=%b s=%b p=%0d h=%0d exp all zero",
                     valid, stalled, period_out, high_out);
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();
        for (int i = 0; i < 40; i++) begin
            cycle(wave(i + 3, 10, 5), e);
            checks++;
            if ({valid, stalled, period_out, high_out} !== e) begin
                errors++;
                $display("FAIL midreset cyc=%0d got v=%b s=%b p=%0d h=%0d exp v=%b s=%b p=%0d h=%0d",
                         i, valid, stalled, period_out, high_out, e.v, e.s, e.p, e.h);
            end
            if (valid) $display("midreset: valid period=%0d high=%0d", period_out, high_out);
        end
    endtask

    task automatic test_random();
        exp_t e;
        int   p, h;
        for (int s = 0; s < 10; s++) begin
            p = int'($urandom_range(70, 2));
            h = int'($urandom_range(p - 1, 1));
            for (int i = 0; i < 3 * p; i++) begin
                cycle(wave(i, p, h), e);
                checks++;
                if ({valid, stalled, period_out, high_out} !== e) begin
                    errors++;
                    $display("FAIL random p=%0d h=%0d cyc=%0d got v=%b s=%b p=%0d h=%0d exp v=%b s=%b p=%0d h=%0d",
                             p, h, i, valid, stalled, period_out, high_out, e.v, e.s, e.p, e.h);
                end
                if (valid) $display("random: valid period=%0d high=%0d", period_out, high_out);
            end
        end
    endtask

    task automatic test_loopback();
        exp_t e;
        int   nv;
        nv = 0;
        for (int i = 0; i < 450; i++) begin
            cycle(1'b0, e);
            checks++;
            if ({valid, stalled, period_out, high_out} !== e) begin
                errors++;
                $display("FAIL loop_idle cyc=%0d got v=%b s=%b p=%0d h=%0d exp v=%b s=%b p=%0d h=%0d",
                         i, valid, stalled, period_out, high_out, e.v, e.s, e.p, e.h);
            end
            if (lb_valid) begin
                nv++;
                checks++;
                if (lb_period !== W'(100) || lb_high !== W'(50) || lb_stalled !== 1'b0) begin
                    errors++;
                    $display("FAIL loopback got p=%0d h=%0d s=%b exp p=100 h=50 s=0",
                             lb_period, lb_high, lb_stalled);
                end
                $display("loopback: valid period=%0d high=%0d", lb_period, lb_high);
            end
        end
        checks++;
        if (nv < 3) begin
            errors++;
            $display("FAIL loopback_count got %0d valids exp at least 3", nv);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_nominal();
        test_odd_min();
        test_timeout();
        test_latency();
        test_midreset();
        test_random();
        test_loopback();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
